// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer driving one shared 1-bit full-adder cell.
// Operands are fed LSB-first, one bit per clock; the carry lives in a flop between bits.
module serial_add_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovf
);

    localparam int            CW       = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Carry-out of the shared 1-bit adder cell.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  sa_r;
    logic [W-1:0]  sb_r;
    logic [W-1:0]  sr_r;
    logic [W-1:0]  result_r;
    logic [W-1:0]  sr_shift_s;
    logic          c_r;
    logic          cm_r;
    logic          cout_r;
    logic          busy_r;
    logic          done_r;
    logic          accept_s;
    logic          last_s;
    logic          sum_s;
    logic          co_s;

    // Adder cell on the current LSBs plus the shifted result it produces.
    always_comb begin
        sum_s      = sa_r[0] ^ sb_r[0] ^ c_r;
        co_s       = maj3(sa_r[0], sb_r[0], c_r);
        sr_shift_s = {sum_s, sr_r[W-1:1]};
        accept_s   = start && ((state_r == IDLE) || (state_r == DONE));
        last_s     = (state_r == RUN) && (cnt_r == LAST_BIT);
    end

    // Next-state logic; start is only honoured from IDLE or DONE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_BIT) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, bit counter and the registered busy/done flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
            if (accept_s) begin
                cnt_r <= {CW{1'b0}};
            end else if (state_r == RUN) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Operand/result shifters; subtract loads ~b with carry-in 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            sa_r     <= {W{1'b0}};
            sb_r     <= {W{1'b0}};
            sr_r     <= {W{1'b0}};
            c_r      <= 1'b0;
            cm_r     <= 1'b0;
            cout_r   <= 1'b0;
            result_r <= {W{1'b0}};
        end else if (accept_s) begin
            sa_r <= a;
            sb_r <= op ? ~b : b;
            sr_r <= {W{1'b0}};
            c_r  <= op;
        end else if (state_r == RUN) begin
            sa_r <= {1'b0, sa_r[W-1:1]};
            sb_r <= {1'b0, sb_r[W-1:1]};
            sr_r <= sr_shift_s;
            c_r  <= co_s;
            // Carry into the MSB is the carry flop just before the last bit is added.
            if (last_s) begin
                cm_r     <= c_r;
                result_r <= sr_shift_s;
                cout_r   <= co_s;
            end else begin
                cm_r     <= cm_r;
                result_r <= result_r;
                cout_r   <= cout_r;
            end
        end else begin
            sa_r <= sa_r;
            sb_r <= sb_r;
            sr_r <= sr_r;
            c_r  <= c_r;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign cout   = cout_r;
    // Both terms are flops updated on the same edge, so ovf holds exactly like cout.
    assign ovf    = cm_r ^ cout_r;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract sequencer for one shared 1-bit full adder cell, of the same function as yAdder1.
- Latches two W-bit operands on a start handshake and feeds them LSB-first through the cell, one bit per clock, with the carry held in a flop.
- Produces the W-bit result, carry-out and signed overflow, with a one-cycle done pulse.
- Sits between the lab's register/operand logic and the 1-bit adder, for area-minimal arithmetic.

Parameters:
W, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only when accept conditions hold
op  input  1  0 = a+b, 1 = a-b (two's complement: b inverted, carry-in 1)
a  input  W  operand A, captured on accepted start
b  input  W  operand B, captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; result/cout/ovf valid
result  output  W  sum/difference, held until next accepted start
cout  output  1  final carry-out (for subtract: 1 = no borrow)
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- States:
  - IDLE, RUN, DONE; 2-bit state register.
  - Bit counter of width clog2(W+1).
  - Shift registers sa, sb, sr (W bits); carry flop c; MSB carry-in flop cm.
- Reset (synchronous, any state, mid-operation included):
  - state=IDLE; busy=0; done=0; result=0; cout=0; ovf=0; c=0; counter=0.
  - Any in-flight operation is discarded; no done pulse follows.
- Accept:
  - start=1 at a rising edge while state is IDLE or DONE.
  - sa<=a, sb<=(op ? ~b : b), c<=op, counter<=0, state<=RUN.
- Ignore: start while in RUN has no effect; operands are not re-sampled.
- RUN, per edge:
  - s = sa[0]^sb[0]^c; co = majority(sa[0], sb[0], c).
  - sr<={s, sr[W-1:1]}; sa, sb shift right by 1; c<=co; counter<=counter+1.
  - When counter==W-1, cm<=c (carry into MSB) is captured before update.
- End of RUN:
  - The edge that processes bit W-1 moves the state to DONE.
  - result<=final shifted sr; cout<=co; ovf<=c^co.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge goes to RUN if start=1, else IDLE.
- Timing:
  - Accepted start at edge 0.
  - busy=1 from after edge 0 through edge W (W cycles); busy = (state==RUN).
  - done=1 in the cycle after edge W.
  - Total latency W+1 cycles from start to done; back-to-back throughput one op per W+1 cycles.
- Holding: result, cout and ovf change only at the end-of-RUN edge or on reset. They keep their previous values during RUN.
- Arithmetic: all modulo 2^W; no saturation; op is captured at accept and ignored afterwards.

Test Plan:
- W=8, start with a=8'h5A, b=8'h33, op=0 -> after 9 cycles, done pulse, result=8'h8D, cout=0, ovf=1; busy high exactly 8 cycles.
- W=8, a=8'hFF, b=8'h01, op=0 -> result=8'h00, cout=1, ovf=0. Then a=8'h80, b=8'h01, op=1 -> result=8'h7F, cout=1, ovf=1.
- W=8, a=8'h10, b=8'h20, op=1 -> result=8'hF0, cout=0 (borrow), ovf=0. A second start pulse with a=8'hAA on cycle 3 of RUN -> ignored; result still 8'hF0.
- Reset asserted on cycle 4 of RUN -> next cycle busy=0, done=0, result=0, no done pulse afterwards. A fresh start then completes normally.
- Back-to-back: start held high through DONE with new operands -> new op accepted in the DONE cycle; second done exactly W+1 cycles after the first.
- W=2 exhaustive: all a, b, op in nested loops -> compare {cout, result} and ovf against a behavioural a+b / a+~b+1 reference with !==; zero mismatches.
